imem_responder: RTL and testbench

Instruction-memory responder for the single-cycle RISC-V core. It accepts fetch requests carrying a byte PC and returns the 32-bit instruction word after a configurable number of wait states. Requests and responses use a valid/ready handshake. A side program port lets benches and the boot loader fill the memory.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/imem_array.sv | 32 +++
 rtl/imem_responder.sv | 103 ++++++++++
 tb/tb_imem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the single-cycle RISC-V core.
//   NOP_INSTR     canonical NOP (addi x0,x0,0)
//   OP_*          7-bit major opcodes
//   imem_state_t  instruction-memory responder FSM states
package riscv_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction storage, one synchronous read port and
// one write port, read-before-write on a same-word collision.
//   clk, reset        clock, asynchronous active-low reset (read register only)
//   re, raddr, rdata  read enable, word index, registered read data
//   we, waddr, wdata  write enable, word index, write data
module imem_array
    import riscv_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata
);
    logic [31:0] mem [DEPTH];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // rdata only updates on re, so later writes never disturb a held word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: valid/ready instruction-fetch responder with WAIT_CYCLES
// wait states and a side program port. Optional macro IMEM_FAULT_CHECK_EN
// enables misalignment/range fault reporting (NOP returned on fault).
//   clk, reset                          clock, asynchronous active-low reset
//   req_valid, req_ready, req_addr      fetch request (byte PC)
//   rsp_valid, rsp_ready                response handshake
//   rsp_instr, rsp_fault                fetched word, fault flag
//   prog_we, prog_addr, prog_data       program port (word index)
module imem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic                     rsp_fault,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    imem_state_t state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] sel_addr;
    logic [31:0] mem_rdata;
    logic        enter_resp;
    logic        fault_d;
    logic        fault_q;

    // With zero wait states the read happens on the accept edge itself,
    // before addr_q has captured the request, so take the live address.
    assign sel_addr   = state == IDLE ? req_addr : addr_q;
    assign enter_resp = (state == IDLE && req_valid && WAIT_CYCLES == 0) ||
                        (state == WAIT && cnt == 4'd1);
    // Gated by reset so ready is low while reset is held, high right after.
    assign req_ready  = reset && state == IDLE;
    assign rsp_fault  = fault_q;
    assign rsp_instr  = fault_q ? NOP_INSTR : mem_rdata;

`ifdef IMEM_FAULT_CHECK_EN
    assign fault_d = (|sel_addr[1:0]) || sel_addr >= 32'(DEPTH * 4);
`else
    logic unused_addr_bits;
    assign fault_d          = 1'b0;
    assign unused_addr_bits = ^{sel_addr[31:AW+2], sel_addr[1:0]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            fault_q   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            if (enter_resp) fault_q <= fault_d;
            case (state)
                IDLE: if (req_valid) begin
                    addr_q    <= req_addr;
                    cnt       <= WAIT_INIT;
                    state     <= WAIT_CYCLES == 0 ? RESP : WAIT;
                    rsp_valid <= WAIT_CYCLES == 0;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .reset (reset),
        .re    (enter_resp),
        .raddr (sel_addr[AW+1:2]),
        .rdata (mem_rdata),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data)
    );
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed bench; instance 0 WAIT_CYCLES=1, 1 WAIT_CYCLES=0,
// 2 WAIT_CYCLES=3, sharing clock, reset, address and program port.
module tb_imem_responder;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] JAL = 32'h010000EF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_addr;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        rv [3];
    logic        rr [3];
    logic        req_ready_w [3];
    logic        rsp_valid_w [3];
    logic [31:0] rsp_instr_w [3];
    logic        rsp_fault_w [3];
    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    logic        seen;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_responder #(.DEPTH(256), .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 3)) dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (rv[g]),
            .req_ready (req_ready_w[g]),
            .req_addr  (req_addr),
            .rsp_valid (rsp_valid_w[g]),
            .rsp_ready (rr[g]),
            .rsp_instr (rsp_instr_w[g]),
            .rsp_fault (rsp_fault_w[g]),
            .prog_we   (prog_we),
            .prog_addr (prog_addr),
            .prog_data (prog_data)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input int i, input logic [31:0] a, input logic [31:0] ei,
                         input logic ef, input int lat, input string tag);
        int n;
        req_addr = a;
        rv[i] = 1'b1;
        @(negedge clk);
        rv[i] = 1'b0;
        n = 1;
        while (!rsp_valid_w[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " instr"}, rsp_instr_w[i], ei);
        chk({tag, " fault"}, {31'd0, rsp_fault_w[i]}, {31'd0, ef});
        rr[i] = 1'b1;
        @(negedge clk);
        rr[i] = 1'b0;
        chk({tag, " valid drop"}, {31'd0, rsp_valid_w[i]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        req_addr = '0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0;
            rr[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready_w[0]}, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid_w[0]}, 32'd0);
        chk("reset rsp_instr", rsp_instr_w[0], 32'd0);
        chk("reset rsp_fault", {31'd0, rsp_fault_w[0]}, 32'd0);
        reset = 1'b1;
        #1;
        chk("release req_ready", {31'd0, req_ready_w[0]}, 32'd1);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = 8'd0;
        prog_data = JAL;
        @(negedge clk);
        prog_addr = 8'd4;
        prog_data = 32'h11111111;
        @(negedge clk);
        prog_we = 1'b0;

        // Basic JAL fetch, WAIT_CYCLES=1
        req_addr = 32'd0;
        rv[0] = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0;
        chk("jal wait ready", {31'd0, req_ready_w[0]}, 32'd0);
        chk("jal wait valid", {31'd0, rsp_valid_w[0]}, 32'd0);
        @(negedge clk);
        chk("jal valid", {31'd0, rsp_valid_w[0]}, 32'd1);
        chk("jal instr", rsp_instr_w[0], JAL);
        chk("jal fault", {31'd0, rsp_fault_w[0]}, 32'd0);
        rr[0] = 1'b1;
        @(negedge clk);
        rr[0] = 1'b0;
        chk("jal done valid", {31'd0, rsp_valid_w[0]}, 32'd0);
        chk("jal done ready", {31'd0, req_ready_w[0]}, 32'd1);

        // Zero-wait back-to-back, WAIT_CYCLES=0
        req_addr = 32'd0;
        rv[1] = 1'b1;
        rr[1] = 1'b1;
        @(negedge clk);
        chk("zw1 valid", {31'd0, rsp_valid_w[1]}, 32'd1);
        chk("zw1 instr", rsp_instr_w[1], JAL);
        chk("zw1 ready low", {31'd0, req_ready_w[1]}, 32'd0);
        req_addr = 32'd16;
        @(negedge clk);
        chk("zw gap valid", {31'd0, rsp_valid_w[1]}, 32'd0);
        chk("zw gap ready", {31'd0, req_ready_w[1]}, 32'd1);
        @(negedge clk);
        rv[1] = 1'b0;
        chk("zw2 valid", {31'd0, rsp_valid_w[1]}, 32'd1);
        chk("zw2 instr", rsp_instr_w[1], 32'h11111111);
        chk("zw2 ready low", {31'd0, req_ready_w[1]}, 32'd0);
        @(negedge clk);
        rr[1] = 1'b0;
        chk("zw2 done", {31'd0, rsp_valid_w[1]}, 32'd0);

        // Backpressure with an ignored request pulse and a later write
        req_addr = 32'd16;
        rv[0] = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0;
        @(negedge clk);
        chk("bp entry valid", {31'd0, rsp_valid_w[0]}, 32'd1);
        chk("bp entry instr", rsp_instr_w[0], 32'h11111111);
        for (int k = 0; k < 5; k++) begin
            rv[0] = (k == 1);
            req_addr = 32'd0;
            prog_we = (k == 2);
            prog_addr = 8'd4;
            prog_data = 32'h33333333;
            @(negedge clk);
            chk("bp hold valid", {31'd0, rsp_valid_w[0]}, 32'd1);
            chk("bp hold instr", rsp_instr_w[0], 32'h11111111);
            chk("bp hold ready", {31'd0, req_ready_w[0]}, 32'd0);
        end
        rv[0] = 1'b0;
        prog_we = 1'b0;
        rr[0] = 1'b1;
        @(negedge clk);
        rr[0] = 1'b0;
        chk("bp release valid", {31'd0, rsp_valid_w[0]}, 32'd0);
        repeat (3) @(negedge clk);
        chk("bp pulse ignored", {31'd0, rsp_valid_w[0]}, 32'd0);

        // Fault path
`ifdef IMEM_FAULT_CHECK_EN
        fetch(0, 32'h2, NOP, 1'b1, 2, "misaligned");
        fetch(0, 32'd1024, NOP, 1'b1, 2, "out of range");
`else
        fetch(0, 32'h2, JAL, 1'b0, 2, "misaligned");
        fetch(0, 32'd1024, JAL, 1'b0, 2, "out of range");
`endif

        // Reset mid-WAIT, WAIT_CYCLES=3
        req_addr = 32'd0;
        rv[2] = 1'b1;
        @(negedge clk);
        rv[2] = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst mid valid", {31'd0, rsp_valid_w[2]}, 32'd0);
        chk("rst mid ready", {31'd0, req_ready_w[2]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst release ready", {31'd0, req_ready_w[2]}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | rsp_valid_w[2];
        end
        chk("rst aborted", {31'd0, seen}, 32'd0);
        fetch(2, 32'd0, JAL, 1'b0, 4, "post reset");

        // Program collision in the RESP-entry cycle
        req_addr = 32'd16;
        rv[0] = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0;
        prog_we = 1'b1;
        prog_addr = 8'd4;
        prog_data = 32'hDEADBEEF;
        @(negedge clk);
        prog_we = 1'b0;
        chk("coll valid", {31'd0, rsp_valid_w[0]}, 32'd1);
        chk("coll old word", rsp_instr_w[0], 32'h33333333);
        rr[0] = 1'b1;
        @(negedge clk);
        rr[0] = 1'b0;
        fetch(0, 32'd16, 32'hDEADBEEF, 1'b0, 2, "coll new word");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
